// File: rtl/lut_multiplier_axi.sv
// Multiplier that looks its product up in a memory-mapped table over an AXI4-lite read.
// Optional macro LUT_MULT_CHECK_EN adds an on-chip product check that folds into error.
module lut_multiplier_axi #(
    parameter int unsigned          OPERAND_W = 3,
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DATA_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          ADDR_LSB  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [OPERAND_W-1:0]     a,
    input  logic [OPERAND_W-1:0]     b,
    output logic                     busy,
    output logic [2*OPERAND_W-1:0]   result,
    output logic                     result_valid,
    output logic                     error,
    output logic [ADDR_W-1:0]        m_axi_araddr,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [DATA_W-1:0]        m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam int unsigned PROD_W = 2 * OPERAND_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] next_addr;
    logic              resp_err;
    logic              prod_err;

    // Table index is the concatenated operand pair, scaled to the slave's addressing.
    always_comb begin
        next_addr = BASE_ADDR + (ADDR_W'({a, b}) << ADDR_LSB);
    end

    assign resp_err      = (m_axi_rresp != 2'b00);
    assign busy          = (state == AR) || (state == R);
    assign m_axi_arvalid = (state == AR);
    assign m_axi_rready  = (state == R);

`ifdef LUT_MULT_CHECK_EN
    logic [OPERAND_W-1:0] a_cap;
    logic [OPERAND_W-1:0] b_cap;
    logic [PROD_W-1:0]    product;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cap <= '0;
            b_cap <= '0;
        end else if (state == IDLE && enable) begin
            a_cap <= a;
            b_cap <= b;
        end
    end

    assign product  = PROD_W'(a_cap) * PROD_W'(b_cap);
    assign prod_err = (m_axi_rdata[PROD_W-1:0] != product);
`else
    assign prod_err = 1'b0;
`endif

    if (DATA_W > PROD_W) begin : g_rdata_upper
        logic unused_rdata_upper;
        assign unused_rdata_upper = ^m_axi_rdata[DATA_W-1:PROD_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            m_axi_araddr <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        m_axi_araddr <= next_addr;
                        error        <= 1'b0;
                        state        <= AR;
                    end
                end
                AR: begin
                    if (m_axi_arready) begin
                        state <= R;
                    end
                end
                R: begin
                    if (m_axi_rvalid) begin
                        result       <= m_axi_rdata[PROD_W-1:0];
                        result_valid <= 1'b1;
                        error        <= resp_err | prod_err;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_multiplier_axi.sv
// Self-checking bench for lut_multiplier_axi: table slave model plus arithmetic reference.
// Honours LUT_MULT_CHECK_EN when choosing the expected error for corrupted table entries.
module tb_lut_multiplier_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable = 1'b0;
    logic [2:0]  a = '0;
    logic [2:0]  b = '0;
    logic        busy;
    logic [5:0]  result;
    logic        result_valid;
    logic        error;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    int vectors     = 0;
    int miscompares = 0;
    int ar_hs       = 0;
    bit corrupt     = 1'b0;

    lut_multiplier_axi #(
        .OPERAND_W(3),
        .ADDR_W(32),
        .DATA_W(32),
        .BASE_ADDR(32'h0),
        .ADDR_LSB(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .a(a),
        .b(b),
        .busy(busy),
        .result(result),
        .result_valid(result_valid),
        .error(error),
        .m_axi_araddr(m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_axi_arvalid && m_axi_arready) ar_hs++;
    end

    // Slave memory: entry at index {x,y} holds x*y, except one entry that can be poisoned.
    function automatic logic [5:0] slave_entry(input logic [31:0] addr);
        int x;
        int y;
        x = int'(addr[5:3]);
        y = int'(addr[2:0]);
        if (corrupt && x == 6 && y == 4) return 6'd23;
        return 6'(x * y);
    endfunction

    task automatic run_txn(input logic [2:0] ai, input logic [2:0] bi, input int ar_dly,
                           input int r_dly, input logic [1:0] resp, input bit poke_r,
                           input string tag);
        logic [31:0] exp_addr;
        logic [31:0] addr_seen;
        logic [31:0] rd;
        logic [5:0]  exp_res;
        logic        exp_err;
        int          hs0;
        exp_addr = 32'(ai) * 8 + 32'(bi);
        exp_res  = 6'(ai) * 6'(bi);
        exp_err  = (resp != 2'b00);
        if (corrupt && ai == 3'd6 && bi == 3'd4) begin
            exp_res = 6'd23;
`ifdef LUT_MULT_CHECK_EN
            exp_err = 1'b1;
`endif
        end
        hs0 = ar_hs;
        enable = 1'b1; a = ai; b = bi;
        @(negedge clk);
        enable = 1'b0; a = 3'($urandom); b = 3'($urandom);
        vectors++;
        if ({busy, m_axi_arvalid, m_axi_rready, result_valid, error} !== 5'b11000) begin
            miscompares++;
            $display("FAIL %s ar_entry: {busy,arvalid,rready,rv,err}=%b want 11000", tag,
                     {busy, m_axi_arvalid, m_axi_rready, result_valid, error});
        end
        vectors++;
        if (m_axi_araddr !== exp_addr) begin
            miscompares++;
            $display("FAIL %s araddr: got %h want %h", tag, m_axi_araddr, exp_addr);
        end
        addr_seen = m_axi_araddr;
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, m_axi_arvalid, m_axi_rready} !== 3'b110 || m_axi_araddr !== exp_addr) begin
                miscompares++;
                $display("FAIL %s ar_stall: {busy,arvalid,rready}=%b addr=%h want 110 %h", tag,
                         {busy, m_axi_arvalid, m_axi_rready}, m_axi_araddr, exp_addr);
            end
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        vectors++;
        if ({busy, m_axi_arvalid, m_axi_rready} !== 3'b101) begin
            miscompares++;
            $display("FAIL %s r_entry: {busy,arvalid,rready}=%b want 101", tag,
                     {busy, m_axi_arvalid, m_axi_rready});
        end
        for (int i = 0; i < r_dly; i++) begin
            if (poke_r && i == 0) begin
                enable = 1'b1; a = 3'($urandom); b = 3'($urandom);
            end
            @(negedge clk);
            enable = 1'b0;
            vectors++;
            if ({busy, m_axi_arvalid, m_axi_rready, result_valid} !== 4'b1010) begin
                miscompares++;
                $display("FAIL %s r_stall: {busy,arvalid,rready,rv}=%b want 1010", tag,
                         {busy, m_axi_arvalid, m_axi_rready, result_valid});
            end
        end
        rd = $urandom;
        rd[5:0] = slave_entry(addr_seen);
        m_axi_rdata = rd; m_axi_rresp = resp; m_axi_rvalid = 1'b1;
        @(negedge clk);
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = $urandom;
        vectors++;
        if ({result_valid, busy, result, error} !== {1'b1, 1'b0, exp_res, exp_err}) begin
            miscompares++;
            $display("FAIL %s complete: rv=%b busy=%b result=%0d err=%b want 1 0 %0d %b", tag,
                     result_valid, busy, result, error, exp_res, exp_err);
        end
        vectors++;
        if (ar_hs - hs0 !== 1) begin
            miscompares++;
            $display("FAIL %s ar_handshakes: got %0d want 1", tag, ar_hs - hs0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        vectors++;
        if ({busy, m_axi_arvalid, m_axi_rready, result_valid, error, result, m_axi_araddr} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b arv=%b rr=%b rv=%b err=%b res=%0d addr=%h want all 0",
                     busy, m_axi_arvalid, m_axi_rready, result_valid, error, result, m_axi_araddr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_txn(3'd5, 3'd7, 0, 0, 2'b00, 1'b0, "basic_5x7");
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if ({result_valid, busy, result, error} !== {1'b0, 1'b0, 6'd35, 1'b0}) begin
                miscompares++;
                $display("FAIL hold: rv=%b busy=%b result=%0d err=%b want 0 0 35 0",
                         result_valid, busy, result, error);
            end
        end
    endtask

    task automatic test_stall();
        run_txn(3'd7, 3'd7, 4, 3, 2'b00, 1'b0, "stall_7x7");
        @(negedge clk);
    endtask

    task automatic test_slverr();
        run_txn(3'd3, 3'd2, 1, 0, 2'b10, 1'b0, "slverr_3x2");
        @(negedge clk);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL slverr_hold: error=%b want 1", error);
        end
        run_txn(3'd2, 3'd2, 0, 0, 2'b00, 1'b0, "after_slverr");
        @(negedge clk);
    endtask

    task automatic test_enable_in_r();
        run_txn(3'd1, 3'd1, 0, 2, 2'b00, 1'b1, "enable_in_r");
        @(negedge clk);
        vectors++;
        if ({busy, m_axi_arvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL enable_in_r_idle: {busy,arvalid}=%b want 00", {busy, m_axi_arvalid});
        end
    endtask

    task automatic test_back_to_back();
        run_txn(3'd2, 3'd3, 0, 0, 2'b00, 1'b0, "b2b_first");
        run_txn(3'd4, 3'd6, 0, 1, 2'b00, 1'b0, "b2b_second");
        run_txn(3'd7, 3'd1, 1, 0, 2'b00, 1'b0, "b2b_third");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; a = 3'd2; b = 3'd3;
        @(negedge clk);
        enable = 1'b0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({busy, m_axi_arvalid, m_axi_rready, result_valid, error, result, m_axi_araddr} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b arv=%b rr=%b rv=%b err=%b res=%0d addr=%h want all 0",
                     busy, m_axi_arvalid, m_axi_rready, result_valid, error, result, m_axi_araddr);
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, result_valid, result} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_after: busy=%b rv=%b result=%0d want 0 0 0", busy, result_valid, result);
        end
        run_txn(3'd4, 3'd5, 0, 0, 2'b00, 1'b0, "post_reset_4x5");
        @(negedge clk);
    endtask

    task automatic test_corrupt();
        corrupt = 1'b1;
        run_txn(3'd6, 3'd4, 0, 0, 2'b00, 1'b0, "corrupt_6x4");
        run_txn(3'd6, 3'd5, 0, 0, 2'b00, 1'b0, "clean_6x5");
        corrupt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int ard;
            int rdl;
            logic [1:0] rsp;
            ard = $urandom_range(0, 3);
            rdl = $urandom_range(0, 3);
            rsp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(3'($urandom), 3'($urandom), ard, rdl, rsp, (rdl > 0) && $urandom_range(0, 1) == 1,
                    "random");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                vectors++;
                if ({result_valid, busy} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL random_idle: {rv,busy}=%b want 00", {result_valid, busy});
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_slverr();
        test_enable_in_r();
        test_back_to_back();
        test_reset_mid();
        test_corrupt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lut_multiplier_axi.md
LUT_MULTIPLIER_AXI -- requirements
Module: lut_multiplier_axi

Interface
REQ-001 The block SHALL have parameter OPERAND_W, default 3, operand width; legal range 1..8.
REQ-002 The block SHALL have parameter ADDR_W, default 32, AXI address width; ADDR_W >= 2*OPERAND_W+ADDR_LSB.
REQ-003 The block SHALL have parameter DATA_W, default 32, AXI read-data width; DATA_W >= 2*OPERAND_W.
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, table base address.
REQ-005 The block SHALL have parameter ADDR_LSB, default 0, left shift applied to table index (0 word-indexed, 2 byte-addressed 32-bit).
REQ-006 The block SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have ports: enable  in  1  request strobe; a  in  OPERAND_W  multiplicand; b  in  OPERAND_W  multiplier; busy  out  1  transaction in flight.
REQ-008 The block SHALL have ports: result  out  2*OPERAND_W  product; result_valid  out  1  one-cycle completion pulse; error  out  1  completion status.
REQ-009 The block SHALL have AXI4-lite read-master ports: m_axi_araddr out ADDR_W; m_axi_arvalid out 1; m_axi_arready in 1; m_axi_rdata in DATA_W; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-010 The block SHALL implement FSM states IDLE, AR, R; busy SHALL be high in AR and R.
REQ-011 In IDLE, enable sampled high SHALL capture a and b, clear error, and move to AR; enable in AR or R SHALL be ignored.
REQ-012 m_axi_araddr SHALL equal BASE_ADDR + ({a_captured,b_captured} << ADDR_LSB), zero-extended to ADDR_W, driven from registers.
REQ-013 In AR, m_axi_arvalid SHALL be high and araddr stable until an edge with m_axi_arready high, then the FSM moves to R.
REQ-014 In R, m_axi_rready SHALL be high; on an edge with m_axi_rvalid high, result SHALL load m_axi_rdata[2*OPERAND_W-1:0], result_valid SHALL pulse for one cycle, and the FSM returns to IDLE.
REQ-015 Minimum latency: enable sampled at edge N, arready high at N+1, rvalid high at N+2 -> result_valid high in the cycle after edge N+2.
REQ-016 error SHALL load 1 at completion when m_axi_rresp != 2'b00, else 0; error and result SHALL hold until the next completion or next accepted enable (error clears on enable).
REQ-017 result SHALL hold its value between completions; rdata bits above 2*OPERAND_W-1 SHALL be ignored.
REQ-018 enable high in the cycle result_valid is high SHALL be accepted (FSM already in IDLE), giving back-to-back requests.
REQ-019 Arbitrarily long arready or rvalid stalls SHALL be tolerated with no timeout; arvalid SHALL never drop before handshake.
REQ-020 m_axi_arvalid and m_axi_rready SHALL never be high simultaneously.

Reset
REQ-021 rst low SHALL asynchronously force state IDLE, busy 0, m_axi_arvalid 0, m_axi_rready 0, m_axi_araddr 0, result 0, result_valid 0, error 0.
REQ-022 Reset asserted mid-transaction SHALL abandon it without producing result_valid; outputs leave reset values only on the first rising clk edge after rst returns high.

Configuration
REQ-023 Macro LUT_MULT_CHECK_EN SHALL compile in a product self-check.
REQ-024 With LUT_MULT_CHECK_EN defined, error at completion SHALL be 1 when rresp != 2'b00 OR rdata[2*OPERAND_W-1:0] != a_captured*b_captured (full 2*OPERAND_W-bit product).
REQ-025 Without LUT_MULT_CHECK_EN, no multiplier SHALL be synthesised and error reflects rresp only.

Verification
REQ-026 Defaults, slave arready/rvalid immediate, table holds a*b: enable with a=5,b=7 -> araddr=0x2F, result=35 (6'b100011), result_valid one cycle after edge N+2, error=0.
REQ-027 arready held low 4 cycles, rvalid delayed 3 cycles, a=7,b=7 -> arvalid high and araddr=0x3F stable throughout, result=49, busy high until completion.
REQ-028 rresp=2'b10 (SLVERR) with a=3,b=2 -> result_valid pulse, error=1; next enable clears error.
REQ-029 enable pulsed during R state with a=1,b=1 -> ignored, only one AR handshake; enable in result_valid cycle -> second transaction starts next cycle.
REQ-030 rst low while arvalid high -> arvalid, busy, result, error 0 immediately, no result_valid; new request after release completes normally.
REQ-031 LUT_MULT_CHECK_EN defined, table entry for a=6,b=4 corrupted to 23, rresp=OKAY -> result=23, error=1; same stimulus without macro -> error=0.
